// File: rtl/mfp_ahb_lite_interconnect.sv
// ---------------------------------------------------------------------------
// mfp_ahb_lite_interconnect
//
// Single-master AHB-Lite interconnect for N slaves. It decodes the address
// phase against a programmable base/mask map and registers the winning
// slave as the data-phase owner whenever HREADY accepts an address phase.
// It then muxes that owner's HRDATA/HREADYOUT/HRESP back to the master.
// Unmapped NONSEQ/SEQ transfers are answered by a built-in default slave
// with the two-cycle AHB ERROR response.
//
// Optional feature (macro MFP_AHB_INTERCONNECT_WATCHDOG_EN): a stall
// watchdog. It aborts a data phase after TIMEOUT_CYCLES consecutive wait
// states with an ERROR response. It also locks the offending slave out of
// decode until that slave reports ready again.
//
// Ports:
//   HCLK, HRESETn        bus clock, asynchronous active-low reset
//   HADDR, HTRANS,
//   HWRITE               master address-phase signals
//   HRDATA, HREADY,
//   HRESP                data-phase response to master
//   S_HSEL               one-hot address-phase slave select (combinational)
//   S_HREADY             copy of HREADY for slave HREADY inputs
//   S_HREADYOUT, S_HRDATA,
//   S_HRESP              per-slave data-phase responses
// ---------------------------------------------------------------------------
module mfp_ahb_lite_interconnect #(
  parameter int unsigned                N_SLAVES       = 4,
  parameter logic [N_SLAVES*32-1:0]     SLAVE_BASE     = {32'h1f400000, 32'h1f800000,
                                                          32'h00000000, 32'h1fc00000},
  parameter logic [N_SLAVES*32-1:0]     SLAVE_MASK     = {32'h1fc00000, 32'h1fc00000,
                                                          32'h10000000, 32'h1fc00000},
  parameter int unsigned                TIMEOUT_CYCLES = 256
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  output logic [31:0]            HRDATA,
  output logic                   HREADY,
  output logic                   HRESP,
  output logic [N_SLAVES-1:0]    S_HSEL,
  output logic                   S_HREADY,
  input  logic [N_SLAVES-1:0]    S_HREADYOUT,
  input  logic [N_SLAVES*32-1:0] S_HRDATA,
  input  logic [N_SLAVES-1:0]    S_HRESP
);

  localparam int unsigned IDXW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [1:0] {
    ST_OKAY,
    ST_ERR1,
    ST_ERR2
  } err_state_e;

  err_state_e        err_q, err_d;
  logic              dsel_vld_q, dsel_vld_d;
  logic [IDXW-1:0]   dsel_idx_q, dsel_idx_d;

  logic              raw_hit;
  logic [IDXW-1:0]   raw_idx;
  logic              dec_hit;
  logic              timeout;
  logic [N_SLAVES-1:0] locked;

  // HWRITE and HTRANS[0] have no influence on routing.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, HWRITE, HTRANS[0]};

  // ---------------------------------------------------------------------
  // Address decode: lowest matching index wins. A locked-out winner makes
  // the whole address unmapped rather than falling through to a
  // lower-priority overlapping slave.
  // ---------------------------------------------------------------------
  always_comb begin
    raw_hit = 1'b0;
    raw_idx = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (!raw_hit && ((HADDR & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])) begin
        raw_hit = 1'b1;
        raw_idx = IDXW'(i);
      end
    end
  end

  assign dec_hit = raw_hit && !locked[raw_idx];

  always_comb begin
    S_HSEL = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      S_HSEL[i] = dec_hit && (raw_idx == IDXW'(i));
    end
  end

  // ---------------------------------------------------------------------
  // Data-phase response mux
  // ---------------------------------------------------------------------
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    case (err_q)
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      ST_ERR2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: begin
        if (dsel_vld_q) begin
          HREADY = S_HREADYOUT[dsel_idx_q];
          HRESP  = S_HRESP[dsel_idx_q];
          HRDATA = S_HRDATA[32*dsel_idx_q +: 32];
        end
      end
    endcase
  end

  assign S_HREADY = HREADY;

  // ---------------------------------------------------------------------
  // Data-phase owner / default-slave next state. ERR1 always advances to
  // ERR2 (HREADY is low, so nothing is accepted). A watchdog abort
  // pre-empts a stalled slave. Otherwise state moves only when HREADY
  // accepts the current address phase.
  // ---------------------------------------------------------------------
  always_comb begin
    err_d      = err_q;
    dsel_vld_d = dsel_vld_q;
    dsel_idx_d = dsel_idx_q;
    if (err_q == ST_ERR1) begin
      err_d = ST_ERR2;
    end else if (timeout) begin
      err_d      = ST_ERR1;
      dsel_vld_d = 1'b0;
    end else if (HREADY) begin
      err_d = ST_OKAY;
      if (dec_hit) begin
        dsel_vld_d = 1'b1;
        dsel_idx_d = raw_idx;
      end else begin
        dsel_vld_d = 1'b0;
        if (HTRANS[1]) begin
          err_d = ST_ERR1;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_q      <= ST_OKAY;
      dsel_vld_q <= 1'b0;
      dsel_idx_q <= '0;
    end else begin
      err_q      <= err_d;
      dsel_vld_q <= dsel_vld_d;
      dsel_idx_q <= dsel_idx_d;
    end
  end

`ifdef MFP_AHB_INTERCONNECT_WATCHDOG_EN
  // ---------------------------------------------------------------------
  // Stall watchdog: counts consecutive wait states of the data-phase owner.
  // The final wait cycle (count == TIMEOUT_CYCLES-1) triggers the abort.
  // ---------------------------------------------------------------------
  logic [15:0]         wd_cnt_q, wd_cnt_d;
  logic [N_SLAVES-1:0] lock_q, lock_d;
  logic                stalled;

  assign stalled = (err_q == ST_OKAY) && dsel_vld_q && !S_HREADYOUT[dsel_idx_q];
  assign timeout = stalled && (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_d = (stalled && !timeout) ? wd_cnt_q + 16'd1 : '0;
    // A lock is released as soon as the slave is seen ready again.
    lock_d   = lock_q & ~S_HREADYOUT;
    if (timeout) begin
      lock_d[dsel_idx_q] = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wd_cnt_q <= '0;
      lock_q   <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      lock_q   <= lock_d;
    end
  end

  assign locked = lock_q;
`else
  assign timeout = 1'b0;
  assign locked  = '0;

  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 32'd1);
`endif

endmodule

// File: tb/tb_mfp_ahb_lite_interconnect.sv
// ---------------------------------------------------------------------------
// tb_mfp_ahb_lite_interconnect
//
// Self-checking bench for mfp_ahb_lite_interconnect (4 slaves, default map,
// TIMEOUT_CYCLES = 8). Each cycle the bench drives the master and slave
// signals, then compares all outputs at the falling edge against a
// transaction-level reference model. Directed sequences cover the listed
// scenarios, followed by a randomized run with occasional resets. The
// watchdog sequence is built only when MFP_AHB_INTERCONNECT_WATCHDOG_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_mfp_ahb_lite_interconnect;

  localparam int TO = 8;
  localparam logic [31:0] BASE [4] = '{32'h1fc00000, 32'h00000000, 32'h1f800000, 32'h1f400000};
  localparam logic [31:0] MASK [4] = '{32'h1fc00000, 32'h10000000, 32'h1fc00000, 32'h1fc00000};

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [31:0]  HRDATA;
  logic         HREADY;
  logic         HRESP;
  logic [3:0]   S_HSEL;
  logic         S_HREADY;
  logic [3:0]   S_HREADYOUT;
  logic [127:0] S_HRDATA;
  logic [3:0]   S_HRESP;

  mfp_ahb_lite_interconnect #(
    .N_SLAVES       (4),
    .SLAVE_BASE     ({32'h1f400000, 32'h1f800000, 32'h00000000, 32'h1fc00000}),
    .SLAVE_MASK     ({32'h1fc00000, 32'h1fc00000, 32'h10000000, 32'h1fc00000}),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .S_HSEL      (S_HSEL),
    .S_HREADY    (S_HREADY),
    .S_HREADYOUT (S_HREADYOUT),
    .S_HRDATA    (S_HRDATA),
    .S_HRESP     (S_HRESP)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the data phase (-1 = nobody), how many ERROR
  // cycles remain, consecutive stall count, and locked-out slaves.
  int          m_owner = -1;
  int          m_err   = 0;
  int          m_wait  = 0;
  bit          m_lock [4];
  logic [31:0] sd [4];

  logic [3:0]  obs_sel;
  logic        obs_rdy;
  logic        obs_resp;
  logic [31:0] obs_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      if ((a & MASK[i]) == BASE[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_err   = 0;
    m_wait  = 0;
    for (int i = 0; i < 4; i++) m_lock[i] = 1'b0;
  endtask

  // One bus cycle: drive, compare at the falling edge, advance the model.
  task automatic step(input logic [31:0] a, input logic [1:0] t, input logic [3:0] rdy,
                      input logic [3:0] rsp, input logic rstn);
    int          dec;
    logic [3:0]  e_sel;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_data;
    bit          stalled;
    bit          tmo;
    HADDR       = a;
    HTRANS      = t;
    HWRITE      = 1'($urandom);
    S_HREADYOUT = rdy;
    S_HRESP     = rsp;
    for (int i = 0; i < 4; i++) sd[i] = {4'(i), 28'($urandom)};
    S_HRDATA    = {sd[3], sd[2], sd[1], sd[0]};
    HRESETn     = rstn;
    if (!rstn) model_reset();
    @(negedge HCLK);

    dec = decode(a);
    if (dec >= 0 && m_lock[dec]) dec = -1;
    e_sel = (dec >= 0) ? 4'(1 << dec) : 4'b0000;
    if (m_err == 2) begin
      e_rdy = 1'b0; e_resp = 1'b1; e_data = '0;
    end else if (m_err == 1) begin
      e_rdy = 1'b1; e_resp = 1'b1; e_data = '0;
    end else if (m_owner >= 0) begin
      e_rdy = rdy[m_owner]; e_resp = rsp[m_owner]; e_data = sd[m_owner];
    end else begin
      e_rdy = 1'b1; e_resp = 1'b0; e_data = '0;
    end

    obs_sel  = S_HSEL;
    obs_rdy  = HREADY;
    obs_resp = HRESP;
    obs_data = HRDATA;
    check("S_HSEL",   32'(obs_sel),  32'(e_sel));
    check("HREADY",   32'(obs_rdy),  32'(e_rdy));
    check("S_HREADY", 32'(S_HREADY), 32'(e_rdy));
    check("HRESP",    32'(obs_resp), 32'(e_resp));
    check("HRDATA",   obs_data,      e_data);

    if (rstn) begin
      stalled = (m_err == 0) && (m_owner >= 0) && !rdy[m_owner];
`ifdef MFP_AHB_INTERCONNECT_WATCHDOG_EN
      for (int i = 0; i < 4; i++) if (rdy[i]) m_lock[i] = 1'b0;
      tmo    = stalled && (m_wait + 1 == TO);
      m_wait = (stalled && !tmo) ? m_wait + 1 : 0;
`else
      tmo = 1'b0;
`endif
      if (m_err == 2) begin
        m_err = 1;
      end else if (tmo) begin
        m_lock[m_owner] = 1'b1;
        m_owner = -1;
        m_err   = 2;
      end else if (e_rdy) begin
        m_err = 0;
        if (dec >= 0) begin
          m_owner = dec;
        end else begin
          m_owner = -1;
          if (t[1]) m_err = 2;
        end
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  initial begin
    logic [31:0] a;
    logic [3:0]  r;
    logic [3:0]  rs;
    HRESETn = 1'b0; HADDR = '0; HTRANS = IDLE; HWRITE = 1'b0;
    S_HREADYOUT = '1; S_HRDATA = '0; S_HRESP = '0;
    model_reset();
    #1;

    // Reset then idle
    step(32'h1f000000, IDLE, 4'hF, 4'h0, 1'b0);
    check("rst_hready", 32'(obs_rdy), 32'd1);
    check("rst_hresp",  32'(obs_resp), 32'd0);
    check("rst_hrdata", obs_data, 32'd0);
    step(32'h1f000000, IDLE, 4'hF, 4'h0, 1'b1);
    check("post_rst_hready", 32'(obs_rdy), 32'd1);

    // Back-to-back reads, no bubble
    step(32'h1fc00000, NONSEQ, 4'hF, 4'h0, 1'b1);
    check("b2b_sel0", 32'(obs_sel), 32'h1);
    step(32'h1f800004, NONSEQ, 4'hF, 4'h0, 1'b1);
    check("b2b_sel2", 32'(obs_sel), 32'h4);
    check("b2b_data0", obs_data, sd[0]);
    step(32'h1f000000, IDLE, 4'hF, 4'h0, 1'b1);
    check("b2b_data2", obs_data, sd[2]);

    // Wait states on slave 1 while next address targets slave 3
    step(32'h00000010, NONSEQ, 4'hF, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(32'h1f400000, NONSEQ, 4'b1101, 4'h0, 1'b1);
      check("ws_hready", 32'(obs_rdy), 32'd0);
      check("ws_data1", obs_data, sd[1]);
    end
    step(32'h1f400000, NONSEQ, 4'hF, 4'h0, 1'b1);
    check("ws_done_data1", obs_data, sd[1]);
    step(32'h1f000000, IDLE, 4'hF, 4'h0, 1'b1);
    check("ws_data3", obs_data, sd[3]);

    // Unmapped NONSEQ: two-cycle ERROR, then OKAY access
    step(32'h1f000000, NONSEQ, 4'hF, 4'h0, 1'b1);
    step(32'h00000010, NONSEQ, 4'hF, 4'h0, 1'b1);
    check("err1_hready", 32'(obs_rdy), 32'd0);
    check("err1_hresp",  32'(obs_resp), 32'd1);
    step(32'h00000010, NONSEQ, 4'hF, 4'h0, 1'b1);
    check("err2_hready", 32'(obs_rdy), 32'd1);
    check("err2_hresp",  32'(obs_resp), 32'd1);
    step(32'h1f000000, IDLE, 4'hF, 4'h0, 1'b1);
    check("after_err_hresp", 32'(obs_resp), 32'd0);
    check("after_err_data1", obs_data, sd[1]);

    // IDLE to unmapped: zero-wait OKAY
    step(32'h1f000000, IDLE, 4'hF, 4'h0, 1'b1);
    check("idle_unm_hready", 32'(obs_rdy), 32'd1);
    check("idle_unm_hresp",  32'(obs_resp), 32'd0);
    check("idle_unm_hrdata", obs_data, 32'd0);

`ifdef MFP_AHB_INTERCONNECT_WATCHDOG_EN
    // Slave 2 stalls: abort after TO wait cycles, lockout until ready
    step(32'h1f800000, NONSEQ, 4'hF, 4'h0, 1'b1);
    for (int i = 0; i < TO; i++) begin
      step(32'h1f800000, NONSEQ, 4'b1011, 4'h0, 1'b1);
      check("wd_wait_hready", 32'(obs_rdy), 32'd0);
      check("wd_wait_hresp",  32'(obs_resp), 32'd0);
    end
    step(32'h1f800000, NONSEQ, 4'b1011, 4'h0, 1'b1);
    check("wd_err1_hresp", 32'(obs_resp), 32'd1);
    check("wd_lock_sel",   32'(obs_sel), 32'd0);
    step(32'h1f800000, NONSEQ, 4'b1011, 4'h0, 1'b1);
    check("wd_err2_hready", 32'(obs_rdy), 32'd1);
    step(32'h1f000000, IDLE, 4'b1011, 4'h0, 1'b1);
    check("wd_locked_err1", 32'(obs_resp), 32'd1);
    step(32'h1f000000, IDLE, 4'b1011, 4'h0, 1'b1);
    check("wd_locked_err2", 32'(obs_rdy), 32'd1);
    step(32'h1f000000, IDLE, 4'hF, 4'h0, 1'b1);
    step(32'h1f800000, NONSEQ, 4'hF, 4'h0, 1'b1);
    check("wd_unlock_sel", 32'(obs_sel), 32'h4);
    step(32'h1f000000, IDLE, 4'hF, 4'h0, 1'b1);
    check("wd_resume_data", obs_data, sd[2]);
`endif

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'h1fc00000 | ($urandom & 32'h003fffff);
        1:       a = 32'h1f800000 | ($urandom & 32'h003fffff);
        2:       a = 32'h1f400000 | ($urandom & 32'h003fffff);
        3:       a = $urandom & 32'hefffffff;
        4:       a = 32'h1f000000 | ($urandom & 32'h003fffff);
        default: a = $urandom;
      endcase
      for (int i = 0; i < 4; i++) begin
        r[i]  = ($urandom_range(0, 3) != 0);
        rs[i] = ($urandom_range(0, 7) == 0);
      end
      step(a, 2'($urandom), r, rs, ($urandom_range(0, 49) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_lite_interconnect.md
# mfp_ahb_lite_interconnect

Parametrised single-master AHB-Lite interconnect with N slaves, programmable base/mask address map, HREADY-qualified data-phase select, built-in default slave issuing the two-cycle AHB ERROR response, and an optional stall watchdog. It sits between the MIPSfpga core bus and all memory and peripheral slaves, and is the successor to the fixed four-slave matrix.

## Interface
- `N_SLAVES`, 4: number of slave ports (1..16).
- `SLAVE_BASE`, {32'h1f400000, 32'h1f800000, 32'h00000000, 32'h1fc00000}: N×32 concatenation; slave i at bits [32i+31:32i].
- `SLAVE_MASK`, {32'h1fc00000, 32'h1fc00000, 32'h10000000, 32'h1fc00000}: N×32; slave i matches when (HADDR & MASK_i) == BASE_i.
- `TIMEOUT_CYCLES`, 256: consecutive wait states before watchdog abort (2..65535).
- `HCLK` in 1: bus clock.
- `HRESETn` in 1: asynchronous active-low reset.
- `HADDR` in 32: master address.
- `HTRANS` in 2: master transfer type.
- `HWRITE` in 1: master direction, passed through.
- `HRDATA` out 32: read data to master.
- `HREADY` out 1: transfer-done to master; also broadcast to slaves.
- `HRESP` out 1: response to master (1 = ERROR).
- `S_HSEL` out N: per-slave select, address phase.
- `S_HREADY` out 1: copy of HREADY for slave HREADY inputs.
- `S_HREADYOUT` in N: per-slave ready.
- `S_HRDATA` in N×32: per-slave read data.
- `S_HRESP` in N: per-slave response.

## Operation
- Decode (combinational): match_i per mask/base; lowest index wins on overlap; S_HSEL = one-hot winner, all-zero if no match. S_HSEL driven regardless of HTRANS; slaves qualify with HTRANS.
- Data-phase state updates only on cycles with HREADY=1 (address phase accepted):
  - matched slave, any HTRANS → DSEL = that slave.
  - no match, HTRANS = NONSEQ/SEQ → state ERR1.
  - no match, IDLE/BUSY → DSEL = none.
- Output mux, DSEL = slave k: HRDATA = S_HRDATA[k], HREADY = S_HREADYOUT[k], HRESP = S_HRESP[k].
- DSEL = none: HRDATA = 0, HREADY = 1, HRESP = 0.
- Default-slave FSM, states OKAY → ERR1 → ERR2 → (next accepted address phase):
  - ERR1: HREADY = 0, HRESP = 1, HRDATA = 0.
  - ERR2: HREADY = 1, HRESP = 1, HRDATA = 0.
  - A master IDLE issued during ERR1 is legal and is sampled in ERR2.
- Simultaneous events: an address phase is accepted in the same cycle the previous data phase completes. No cycle is lost between back-to-back transfers to different slaves.
- Reset mid-transfer: all state is forced to DSEL = none and OKAY immediately. The in-flight transfer is discarded.

## Timing
- Reset values: HREADY = 1, HRESP = 0, HRDATA = 0, S_HREADY = 1. S_HSEL is combinational from HADDR.
- Decode and mux add zero cycles of latency. Data-phase state is registered on the HCLK rising edge.
- Unmapped NONSEQ: exactly 2 data-phase cycles (ERR1, ERR2).
- A zero-wait slave gives 1 data-phase cycle; a slave with w wait states gives w+1 cycles.

## Configuration
- Macro: `MFP_AHB_INTERCONNECT_WATCHDOG_EN`.
- When defined:
  - A 16-bit counter increments each cycle that DSEL = slave k and S_HREADYOUT[k] = 0, and clears otherwise.
  - When the count reaches TIMEOUT_CYCLES−1, the next cycle enters ERR1/ERR2. The master sees the two-cycle ERROR; DSEL is then released.
  - Slave k is locked out (S_HSEL[k] forced 0, decode treated as unmapped) until S_HREADYOUT[k] = 1 is observed.
- When not defined: no counter and no lockout. A stalled slave stalls the bus indefinitely.

## Test plan
- Reset then idle: HRESETn low with HTRANS = IDLE → HREADY = 1, HRESP = 0, HRDATA = 0 during and after reset.
- Back-to-back reads 0x1fc00000 then 0x1f800004:
  - S_HSEL = 4'b0001, then 4'b0100.
  - HRDATA returns S_HRDATA[0] and then S_HRDATA[2] on consecutive cycles, with no bubble.
- Wait-state and dirty-select check:
  - Slave 1 holds S_HREADYOUT[1] = 0 for 3 cycles while the next address targets slave 3.
  - HREADY stays 0 for 3 cycles and DSEL stays 1.
  - Slave 3 data appears only after slave 1 completes.
- NONSEQ to unmapped 0x1f000000:
  - Cycle 1: HREADY = 0, HRESP = 1.
  - Cycle 2: HREADY = 1, HRESP = 1.
  - The following access to 0x00000010 returns OKAY.
- IDLE to 0x1f000000 → zero-wait OKAY, HRDATA = 0.
- With `MFP_AHB_INTERCONNECT_WATCHDOG_EN` and TIMEOUT_CYCLES = 8, slave 2 held not-ready:
  - ERROR response after 8 wait cycles.
  - The next NONSEQ to 0x1f800000 gets ERROR while S_HSEL[2] = 0.
  - Normal access resumes once S_HREADYOUT[2] rises.
